// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcode values, FSM state encoding and ALU operation
// selection for the accumulator core and its ALU.
package cpu_pkg;

    localparam int unsigned OPC_W = 4;

    localparam logic [OPC_W-1:0] OP_NOP = 4'h0;
    localparam logic [OPC_W-1:0] OP_LDI = 4'h1;
    localparam logic [OPC_W-1:0] OP_LD  = 4'h2;
    localparam logic [OPC_W-1:0] OP_ST  = 4'h3;
    localparam logic [OPC_W-1:0] OP_ADD = 4'h4;
    localparam logic [OPC_W-1:0] OP_SUB = 4'h5;
    localparam logic [OPC_W-1:0] OP_AND = 4'h6;
    localparam logic [OPC_W-1:0] OP_OR  = 4'h7;
    localparam logic [OPC_W-1:0] OP_XOR = 4'h8;
    localparam logic [OPC_W-1:0] OP_JMP = 4'h9;
    localparam logic [OPC_W-1:0] OP_JZ  = 4'hA;
    localparam logic [OPC_W-1:0] OP_JC  = 4'hB;
    localparam logic [OPC_W-1:0] OP_HLT = 4'hF;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_MEM   = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        ALU_PASS = 3'd0,
        ALU_ADD  = 3'd1,
        ALU_SUB  = 3'd2,
        ALU_AND  = 3'd3,
        ALU_OR   = 3'd4,
        ALU_XOR  = 3'd5
    } alu_op_e;

    // Map an opcode to the ALU operation; loads (LDI, LD) pass operand B through.
    function automatic alu_op_e alu_op_of(input logic [OPC_W-1:0] opc);
        alu_op_e op;
        case (opc)
            OP_ADD:  op = ALU_ADD;
            OP_SUB:  op = ALU_SUB;
            OP_AND:  op = ALU_AND;
            OP_OR:   op = ALU_OR;
            OP_XOR:  op = ALU_XOR;
            default: op = ALU_PASS;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// cpu_alu: combinational accumulator ALU.
//   op_i       operation select
//   a_i, b_i   operands (a = accumulator, b = immediate or memory data)
//   result_c_o DATA_W-bit result
//   carry_c_o  carry-out for ADD, borrow (a < b) for SUB, don't-care otherwise
//   zero_c_o   result == 0
module cpu_alu
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  alu_op_e           op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] result_c_o,
    output logic              carry_c_o,
    output logic              zero_c_o
);

    logic [DATA_W:0] ext_a_c;
    logic [DATA_W:0] ext_b_c;
    logic [DATA_W:0] wide_c;

    // One extra bit holds carry-out on add and the borrow on subtract.
    always_comb begin
        ext_a_c = {1'b0, a_i};
        ext_b_c = {1'b0, b_i};
        wide_c  = ext_b_c;
        case (op_i)
            ALU_ADD: wide_c = ext_a_c + ext_b_c;
            ALU_SUB: wide_c = ext_a_c - ext_b_c;
            ALU_AND: wide_c = {1'b0, a_i & b_i};
            ALU_OR:  wide_c = {1'b0, a_i | b_i};
            ALU_XOR: wide_c = {1'b0, a_i ^ b_i};
            default: wide_c = ext_b_c;
        endcase
        result_c_o = wide_c[DATA_W-1:0];
        carry_c_o  = wide_c[DATA_W];
        zero_c_o   = (wide_c[DATA_W-1:0] == '0);
    end

endmodule

// File: rtl/cpu_core_param.sv
// cpu_core_param: multi-cycle accumulator core (FETCH / EXEC / MEM / HALT).
//   clk, reset_n          clock, asynchronous active-low reset
//   imem_req/addr/rdata/ready  instruction fetch handshake (addr = PC)
//   dmem_req/we/addr/wdata/rdata/ready  data access handshake
//   run                   resume from HALT
//   halted, acc, flags    status: in HALT, accumulator, {C, Z}
module cpu_core_param
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned PC_W   = 10
) (
    input  logic                    clk,
    input  logic                    reset_n,
    output logic                    imem_req,
    output logic [PC_W-1:0]         imem_addr,
    input  logic [OPC_W+ADDR_W-1:0] imem_rdata,
    input  logic                    imem_ready,
    output logic                    dmem_req,
    output logic                    dmem_we,
    output logic [ADDR_W-1:0]       dmem_addr,
    output logic [DATA_W-1:0]       dmem_wdata,
    input  logic [DATA_W-1:0]       dmem_rdata,
    input  logic                    dmem_ready,
    input  logic                    run,
    output logic                    halted,
    output logic [DATA_W-1:0]       acc,
    output logic [1:0]              flags
);

    localparam int unsigned INSTR_W = OPC_W + ADDR_W;

    state_e              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [INSTR_W-1:0]  ir_q, ir_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic                c_q, c_d;
    logic                z_q, z_d;
    logic                imem_req_q, imem_req_d;
    logic                dmem_req_q, dmem_req_d;
    logic                dmem_we_q, dmem_we_d;
    logic [ADDR_W-1:0]   dmem_addr_q, dmem_addr_d;
    logic [DATA_W-1:0]   dmem_wdata_q, dmem_wdata_d;
    logic                halted_q, halted_d;

    logic [OPC_W-1:0]    opc_c;
    logic [ADDR_W-1:0]   opnd_c;
    alu_op_e             alu_op_c;
    logic [DATA_W-1:0]   alu_b_c;
    logic [DATA_W-1:0]   alu_res_c;
    logic                alu_carry_c;
    logic                alu_zero_c;

    assign opc_c    = ir_q[INSTR_W-1 -: OPC_W];
    assign opnd_c   = ir_q[ADDR_W-1:0];
    assign alu_op_c = alu_op_of(opc_c);
    // Immediate operand in EXEC, memory read data in MEM.
    assign alu_b_c  = (state_q == ST_MEM) ? dmem_rdata : DATA_W'(opnd_c);

    cpu_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .op_i       (alu_op_c),
        .a_i        (acc_q),
        .b_i        (alu_b_c),
        .result_c_o (alu_res_c),
        .carry_c_o  (alu_carry_c),
        .zero_c_o   (alu_zero_c)
    );

    // Next-state and next-output logic; request flags are registered so that
    // imem_req and dmem_req follow the state they belong to.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ir_d         = ir_q;
        acc_d        = acc_q;
        c_d          = c_q;
        z_d          = z_q;
        imem_req_d   = imem_req_q;
        dmem_req_d   = dmem_req_q;
        dmem_we_d    = dmem_we_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_wdata_d = dmem_wdata_q;
        halted_d     = halted_q;

        case (state_q)
            ST_FETCH: begin
                if (imem_req_q && imem_ready) begin
                    ir_d       = imem_rdata;
                    pc_d       = pc_q + PC_W'(1);
                    imem_req_d = 1'b0;
                    state_d    = ST_EXEC;
                end
            end

            ST_EXEC: begin
                // Single-cycle ops fall back to FETCH unless overridden below.
                state_d    = ST_FETCH;
                imem_req_d = 1'b1;
                case (opc_c)
                    OP_LDI: begin
                        acc_d = alu_res_c;
                        z_d   = alu_zero_c;
                    end
                    OP_JMP: pc_d = PC_W'(opnd_c);
                    OP_JZ:  if (z_q) pc_d = PC_W'(opnd_c);
                    OP_JC:  if (c_q) pc_d = PC_W'(opnd_c);
                    OP_LD, OP_ST, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                        state_d      = ST_MEM;
                        imem_req_d   = 1'b0;
                        dmem_req_d   = 1'b1;
                        dmem_we_d    = (opc_c == OP_ST);
                        dmem_addr_d  = opnd_c;
                        dmem_wdata_d = acc_q;
                    end
                    OP_HLT: begin
                        state_d    = ST_HALT;
                        imem_req_d = 1'b0;
                        halted_d   = 1'b1;
                    end
                    default: ;
                endcase
            end

            ST_MEM: begin
                if (dmem_req_q && dmem_ready) begin
                    if (opc_c != OP_ST) begin
                        acc_d = alu_res_c;
                        z_d   = alu_zero_c;
                        if (opc_c == OP_ADD || opc_c == OP_SUB) c_d = alu_carry_c;
                    end
                    dmem_req_d = 1'b0;
                    dmem_we_d  = 1'b0;
                    imem_req_d = 1'b1;
                    state_d    = ST_FETCH;
                end
            end

            ST_HALT: begin
                if (run) begin
                    halted_d   = 1'b0;
                    imem_req_d = 1'b1;
                    state_d    = ST_FETCH;
                end
            end

            default: begin
                state_d    = ST_FETCH;
                imem_req_d = 1'b1;
            end
        endcase
    end

    // Reset lands in FETCH with the PC-0 request already raised.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_FETCH;
            pc_q         <= '0;
            ir_q         <= '0;
            acc_q        <= '0;
            c_q          <= 1'b0;
            z_q          <= 1'b0;
            imem_req_q   <= 1'b1;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ir_q         <= ir_d;
            acc_q        <= acc_d;
            c_q          <= c_d;
            z_q          <= z_d;
            imem_req_q   <= imem_req_d;
            dmem_req_q   <= dmem_req_d;
            dmem_we_q    <= dmem_we_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wdata_q <= dmem_wdata_d;
            halted_q     <= halted_d;
        end
    end

    assign imem_req   = imem_req_q;
    assign imem_addr  = pc_q;
    assign dmem_req   = dmem_req_q;
    assign dmem_we    = dmem_we_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_wdata = dmem_wdata_q;
    assign halted     = halted_q;
    assign acc        = acc_q;
    assign flags      = {c_q, z_q};

endmodule

// File: tb/tb_cpu_core_param.sv
// tb_cpu_core_param: directed programs with hand-computed results on a
// default-width core (u_dut0) and a DATA_W=16 / ADDR_W=10 core (u_dut1).
`timescale 1ns/1ps
module tb_cpu_core_param;
    import cpu_pkg::*;

    localparam int unsigned D0 = 8;
    localparam int unsigned A0 = 8;
    localparam int unsigned P0 = 10;
    localparam int unsigned I0 = 12;
    localparam int unsigned D1 = 16;
    localparam int unsigned A1 = 10;
    localparam int unsigned P1 = 10;
    localparam int unsigned I1 = 14;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic run = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // ---------------- instance 0 (default widths) ----------------
    logic          imem_req0, imem_ready0;
    logic [P0-1:0] imem_addr0;
    logic [I0-1:0] imem_rdata0;
    logic          dmem_req0, dmem_we0, dmem_ready0;
    logic [A0-1:0] dmem_addr0;
    logic [D0-1:0] dmem_wdata0, dmem_rdata0;
    logic          halted0;
    logic [D0-1:0] acc0;
    logic [1:0]    flags0;

    logic [I0-1:0] imem0 [0:1023];
    logic [D0-1:0] dmem0 [0:255];
    int            dlat0 = 0;
    int            wait0 = 0;
    int            wr_cnt0 = 0;
    logic [A0-1:0] last_wr_addr0 = '0;
    logic [D0-1:0] last_wr_data0 = '0;

    assign imem_rdata0 = imem0[imem_addr0];
    assign imem_ready0 = imem_req0;
    assign dmem_rdata0 = dmem0[dmem_addr0];
    assign dmem_ready0 = dmem_req0 && (wait0 >= dlat0);

    always @(posedge clk) begin
        if (!dmem_req0 || dmem_ready0) wait0 <= 0;
        else                           wait0 <= wait0 + 1;
        if (dmem_req0 && dmem_ready0 && dmem_we0) begin
            wr_cnt0       <= wr_cnt0 + 1;
            last_wr_addr0 <= dmem_addr0;
            last_wr_data0 <= dmem_wdata0;
        end
    end

    cpu_core_param #(.DATA_W(D0), .ADDR_W(A0), .PC_W(P0)) u_dut0 (
        .clk        (clk),
        .reset_n    (reset_n),
        .imem_req   (imem_req0),
        .imem_addr  (imem_addr0),
        .imem_rdata (imem_rdata0),
        .imem_ready (imem_ready0),
        .dmem_req   (dmem_req0),
        .dmem_we    (dmem_we0),
        .dmem_addr  (dmem_addr0),
        .dmem_wdata (dmem_wdata0),
        .dmem_rdata (dmem_rdata0),
        .dmem_ready (dmem_ready0),
        .run        (run),
        .halted     (halted0),
        .acc        (acc0),
        .flags      (flags0)
    );

    // ---------------- instance 1 (16-bit data, 10-bit operand) ----------------
    logic          imem_req1, imem_ready1;
    logic [P1-1:0] imem_addr1;
    logic [I1-1:0] imem_rdata1;
    logic          dmem_req1, dmem_we1, dmem_ready1;
    logic [A1-1:0] dmem_addr1;
    logic [D1-1:0] dmem_wdata1, dmem_rdata1;
    logic          halted1;
    logic [D1-1:0] acc1;
    logic [1:0]    flags1;

    logic [I1-1:0] imem1 [0:1023];
    logic [D1-1:0] dmem1 [0:1023];

    assign imem_rdata1 = imem1[imem_addr1];
    assign imem_ready1 = imem_req1;
    assign dmem_rdata1 = dmem1[dmem_addr1];
    assign dmem_ready1 = dmem_req1;

    cpu_core_param #(.DATA_W(D1), .ADDR_W(A1), .PC_W(P1)) u_dut1 (
        .clk        (clk),
        .reset_n    (reset_n),
        .imem_req   (imem_req1),
        .imem_addr  (imem_addr1),
        .imem_rdata (imem_rdata1),
        .imem_ready (imem_ready1),
        .dmem_req   (dmem_req1),
        .dmem_we    (dmem_we1),
        .dmem_addr  (dmem_addr1),
        .dmem_wdata (dmem_wdata1),
        .dmem_rdata (dmem_rdata1),
        .dmem_ready (dmem_ready1),
        .run        (run),
        .halted     (halted1),
        .acc        (acc1),
        .flags      (flags1)
    );

    int overlap = 0;
    always @(negedge clk) begin
        if ((imem_req0 && dmem_req0) || (imem_req1 && dmem_req1)) overlap <= overlap + 1;
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [I0-1:0] e0(input logic [3:0] op, input logic [A0-1:0] x);
        return {op, x};
    endfunction

    function automatic logic [I1-1:0] e1(input logic [3:0] op, input logic [A1-1:0] x);
        return {op, x};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) begin
            imem0[i] = '0;
            imem1[i] = '0;
            dmem1[i] = '0;
        end
        for (int i = 0; i < 256; i++) dmem0[i] = '0;
    endtask

    task automatic hold_reset();
        @(negedge clk);
        reset_n = 1'b0;
        run     = 1'b0;
        @(negedge clk);
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic wait_halt(input int inst, input string tag);
        for (int i = 0; i < 300; i++) begin
            if ((inst == 0) ? halted0 : halted1) break;
            @(negedge clk);
        end
        check(tag, (inst == 0) ? halted0 : halted1, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- directed tests ----------------
    initial begin
        logic quiet;
        logic found;
        logic stable;
        int   wr_base;

        // LDI 5; ADD [0x10]=0xFB; HLT -> 0x100 wraps to 0, C=1 Z=1
        hold_reset();
        clear_mem();
        imem0[0] = e0(OP_LDI, 8'h05);
        imem0[1] = e0(OP_ADD, 8'h10);
        imem0[2] = e0(OP_HLT, 8'h00);
        dmem0[8'h10] = 8'hFB;
        dlat0 = 0;
        #1;
        check("rst_dmem_req", dmem_req0, 0);
        check("rst_halted", halted0, 0);
        check("rst_imem_addr", imem_addr0, 0);
        release_reset();
        #1;
        check("first_fetch_req", imem_req0, 1);
        check("first_fetch_addr", imem_addr0, 0);
        wait_halt(0, "add_halt");
        check("add_acc", acc0, 8'h00);
        check("add_flags", flags0, 2'b11);
        check("add_pc", imem_addr0, 3);

        // Halted with run low: no requests for 10 cycles, then resume at 3
        imem0[3] = e0(OP_LDI, 8'h2A);
        imem0[4] = e0(OP_HLT, 8'h00);
        quiet = 1'b0;
        repeat (10) begin
            @(negedge clk);
            quiet = quiet | imem_req0 | dmem_req0;
        end
        check("halt_no_req", quiet, 0);
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        check("resume_req", imem_req0, 1);
        check("resume_addr", imem_addr0, 3);
        wait_halt(0, "resume_halt");
        check("resume_acc", acc0, 8'h2A);
        check("resume_flags", flags0, 2'b10);
        check("resume_pc", imem_addr0, 5);

        // ST with three wait states: request held stable for four cycles
        hold_reset();
        clear_mem();
        imem0[0] = e0(OP_LDI, 8'h5A);
        imem0[1] = e0(OP_ST, 8'h20);
        imem0[2] = e0(OP_HLT, 8'h00);
        dlat0 = 3;
        wr_base = wr_cnt0;
        release_reset();
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (dmem_req0) begin
                found = 1'b1;
                break;
            end
        end
        check("st_req_seen", found, 1);
        stable = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            stable = stable & (dmem_req0 === 1'b1) & (dmem_we0 === 1'b1)
                   & (dmem_addr0 === 8'h20) & (dmem_wdata0 === 8'h5A);
        end
        check("st_stable_4cyc", stable, 1);
        check("st_no_early_write", wr_cnt0 - wr_base, 0);
        @(negedge clk);
        check("st_req_drop", dmem_req0, 0);
        wait_halt(0, "st_halt");
        check("st_write_count", wr_cnt0 - wr_base, 1);
        check("st_write_addr", last_wr_addr0, 8'h20);
        check("st_write_data", last_wr_data0, 8'h5A);
        check("st_flags", flags0, 2'b00);

        // Logic ops, taken JC/JZ, JMP, LD, opcode C as NOP, SUB to zero
        hold_reset();
        clear_mem();
        imem0[0]  = e0(OP_LDI, 8'hF0);
        imem0[1]  = e0(OP_ADD, 8'h50);
        imem0[2]  = e0(OP_JC,  8'h05);
        imem0[3]  = e0(OP_HLT, 8'h00);
        imem0[4]  = e0(OP_HLT, 8'h00);
        imem0[5]  = e0(OP_AND, 8'h51);
        imem0[6]  = e0(OP_OR,  8'h52);
        imem0[7]  = e0(OP_XOR, 8'h53);
        imem0[8]  = e0(OP_JZ,  8'h0A);
        imem0[9]  = e0(OP_HLT, 8'h00);
        imem0[10] = e0(OP_LD,  8'h54);
        imem0[11] = e0(4'hC,   8'h00);
        imem0[12] = e0(OP_JMP, 8'h0E);
        imem0[13] = e0(OP_HLT, 8'h00);
        imem0[14] = e0(OP_SUB, 8'h55);
        imem0[15] = e0(OP_HLT, 8'h00);
        dmem0[8'h50] = 8'h20;
        dmem0[8'h51] = 8'h30;
        dmem0[8'h52] = 8'h0F;
        dmem0[8'h53] = 8'h1F;
        dmem0[8'h54] = 8'h80;
        dmem0[8'h55] = 8'h80;
        dlat0 = 1;
        release_reset();
        wait_halt(0, "alu_halt");
        check("alu_pc", imem_addr0, 16);
        check("alu_acc", acc0, 8'h00);
        check("alu_flags", flags0, 2'b01);

        // SUB 3 - 5 on both widths
        hold_reset();
        clear_mem();
        imem0[0] = e0(OP_LDI, 8'h03);
        imem0[1] = e0(OP_SUB, 8'h30);
        imem0[2] = e0(OP_HLT, 8'h00);
        dmem0[8'h30] = 8'h05;
        imem1[0] = e1(OP_LDI, 10'h003);
        imem1[1] = e1(OP_SUB, 10'h030);
        imem1[2] = e1(OP_HLT, 10'h000);
        dmem1[10'h030] = 16'h0005;
        dlat0 = 0;
        release_reset();
        wait_halt(0, "sub8_halt");
        wait_halt(1, "sub16_halt");
        check("sub8_acc", acc0, 8'hFE);
        check("sub8_flags", flags0, 2'b10);
        check("sub16_acc", acc1, 16'hFFFE);
        check("sub16_flags", flags1, 2'b10);

        // Taken JZ to 0x3FF, NOP there, fetch wraps to 0x000
        hold_reset();
        clear_mem();
        imem1[0]      = e1(OP_LDI, 10'h000);
        imem1[1]      = e1(OP_JZ,  10'h3FF);
        imem1[10'h3FF] = e1(OP_NOP, 10'h000);
        release_reset();
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (imem_req1 && imem_addr1 == 10'h3FF) begin
                found = 1'b1;
                break;
            end
        end
        check("jz_reach_3ff", found, 1);
        for (int i = 0; i < 20 && imem_req1; i++) @(negedge clk);
        for (int i = 0; i < 20 && !imem_req1; i++) @(negedge clk);
        check("wrap_req", imem_req1, 1);
        check("wrap_addr", imem_addr1, 10'h000);
        check("wrap_flags", flags1, 2'b01);

        // LDI 1 makes JZ fall through
        hold_reset();
        clear_mem();
        imem1[0] = e1(OP_LDI, 10'h001);
        imem1[1] = e1(OP_JZ,  10'h3FF);
        imem1[2] = e1(OP_HLT, 10'h000);
        release_reset();
        wait_halt(1, "jz_nt_halt");
        check("jz_nt_pc", imem_addr1, 3);
        check("jz_nt_acc", acc1, 16'h0001);

        // Reset during a stalled LD abandons the access
        hold_reset();
        clear_mem();
        imem0[0] = e0(OP_LDI, 8'h33);
        imem0[1] = e0(OP_LD,  8'h40);
        imem0[2] = e0(OP_HLT, 8'h00);
        dmem0[8'h40] = 8'h77;
        dlat0 = 20;
        release_reset();
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (dmem_req0) begin
                found = 1'b1;
                break;
            end
        end
        check("ld_req_seen", found, 1);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_dmem_req", dmem_req0, 0);
        check("async_rst_dmem_we", dmem_we0, 0);
        check("async_rst_acc", acc0, 8'h00);
        check("async_rst_flags", flags0, 2'b00);
        check("async_rst_pc", imem_addr0, 0);
        dlat0 = 0;
        @(negedge clk);
        release_reset();
        #1;
        check("post_rst_req", imem_req0, 1);
        check("post_rst_addr", imem_addr0, 0);
        wait_halt(0, "ld_halt");
        check("ld_acc", acc0, 8'h77);
        check("ld_flags", flags0, 2'b00);

        check("no_req_overlap", overlap, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cpu_core_param.md
CPU_CORE_PARAM -- requirements
Module: cpu_core_param

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning accumulator and data-memory word width (4..32).
REQ-002 SHALL have parameter ADDR_W, default 8, meaning operand / data-memory address width; INSTR_W = 4 + ADDR_W.
REQ-003 SHALL have parameter PC_W, default 10, meaning program-counter and instruction-address width.
REQ-004 SHALL have ports, one clock and an asynchronous active-low reset:
- clk  input  1  sole clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- imem_req  output  1  instruction fetch request.
- imem_addr  output  PC_W  fetch address (= PC).
- imem_rdata  input  INSTR_W  instruction, [INSTR_W-1 -: 4] opcode, [ADDR_W-1:0] operand.
- imem_ready  input  1  fetch complete this cycle.
- dmem_req  output  1  data access request.
- dmem_we  output  1  1 = write, 0 = read.
- dmem_addr  output  ADDR_W  data address (= operand).
- dmem_wdata  output  DATA_W  write data (= ACC).
- dmem_rdata  input  DATA_W  read data, valid with dmem_ready.
- dmem_ready  input  1  data access complete this cycle.
- run  input  1  resume from halt.
- halted  output  1  core is in HALT.
- acc  output  DATA_W  accumulator.
- flags  output  2  {C, Z}.

Function
REQ-005 SHALL implement FSM states FETCH, EXEC, MEM, HALT; no clock gating, halt is a state.
REQ-006 FETCH: assert imem_req with imem_addr = PC; on imem_ready, latch IR, PC <= PC+1 modulo 2^PC_W, go to EXEC. Zero-wait ready in the first cycle is legal.
REQ-007 Opcodes: 0 NOP, 1 LDI, 2 LD, 3 ST, 4 ADD, 5 SUB, 6 AND, 7 OR, 8 XOR, 9 JMP, A JZ, B JC, F HLT; B..E other than B SHALL act as NOP.
REQ-008 EXEC, single-cycle ops (NOP, LDI, JMP, JZ, JC) SHALL complete and return to FETCH. LDI loads the operand, zero-extended or truncated to DATA_W.
REQ-009 Jumps SHALL load PC with the operand, zero-extended or truncated to PC_W. JZ is taken only if Z=1 and JC only if C=1; untaken jumps leave PC at PC+1.
REQ-010 EXEC, memory ops (LD, ST, ADD, SUB, AND, OR, XOR) SHALL go to MEM. HLT SHALL go to HALT.
REQ-011 MEM: assert dmem_req and hold dmem_addr, dmem_we (1 only for ST) and dmem_wdata stable until dmem_ready. On ready, write back ACC and go to FETCH.
REQ-012 ALU on DATA_W bits: ADD sets C = carry-out; SUB sets C = borrow (ACC < operand); AND, OR, XOR and LD leave C unchanged.
REQ-013 Z SHALL be updated to (new ACC == 0) on every ACC write. ST, jumps and NOP leave both flags unchanged.
REQ-014 HALT: halted = 1, no requests. run = 1 sampled in HALT SHALL go to FETCH next cycle with PC unchanged. run outside HALT SHALL be ignored.
REQ-015 imem_req and dmem_req SHALL never be asserted in the same cycle.
REQ-016 A ready input without its request asserted SHALL be ignored.

Reset
REQ-017 reset_n low SHALL immediately set state FETCH, PC = 0, IR = 0, ACC = 0, flags = 00, halted = 0, dmem_req = 0, dmem_we = 0. This holds mid-access; the outstanding access is abandoned.
REQ-018 The first fetch, of address 0, SHALL be requested in the first cycle after reset_n deasserts.

Structure
REQ-019 Opcode localparams and the FSM state encoding SHALL live in a shared package, cpu_pkg, which replaces the flat opcode include for this block.
REQ-020 The combinational ALU (result, carry/borrow, zero) SHALL be one sub-module, cpu_alu, parametrised by DATA_W. Everything else is flat.

Verification
REQ-021 Reset, then program LDI 0x05; ADD [0x10] (mem 0x10 = 0xFB); HLT, with zero-wait memories -> ACC = 0x00, flags = {C=1, Z=1}, halted = 1 at PC = 3.
REQ-022 ST with dmem_ready delayed 3 cycles -> dmem_req, dmem_addr, dmem_we and dmem_wdata stable all 4 cycles, and a single write is observed.
REQ-023 LDI 0x00; JZ 0x3FF; at 0x3FF NOP -> after the NOP, fetch address wraps to 0x000. With LDI 0x01 instead, JZ is not taken.
REQ-024 SUB with ACC = 0x03 and mem = 0x05 -> ACC = 0xFE, C = 1, Z = 0. Repeat with DATA_W = 16, ADDR_W = 10 -> ACC = 0xFFFE.
REQ-025 HLT, hold run = 0 for 10 cycles -> no requests. Pulse run -> fetch resumes at the address after HLT.
REQ-026 Assert reset_n low during a stalled LD -> dmem_req drops asynchronously, and after release the first imem_addr is 0.
